// File: rtl/siso_shift_arbiter.sv
// rtl/siso_shift_arbiter.sv - round-robin arbiter feeding one MSB-first serial shift path
//
// Purpose: NUM_REQ producers compete for a single DATA_WIDTH-bit serializer.
// The arbiter grants round-robin, captures the winner's word on a valid/ready
// handshake, shifts it out MSB-first one bit per clock, then forces GAP_CYCLES
// idle cycles before arbitrating again.
//
// Ports:
//   Clk_In            rising-edge clock
//   Reset_In          asynchronous active-low reset
//   Req_Valid_In      per-requester word valid
//   Req_Data_In       word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   Req_Ready_Out     one-hot accept, only while idle
//   Serial_Data_Out   serial bit, MSB first, 0 outside a frame
//   Frame_Active_Out  high while Serial_Data_Out carries a bit
//   Grant_Id_Out      requester owning the current (or last) frame
//   Done_Out          one-cycle pulse in the cycle after the last bit
module siso_shift_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                          Clk_In,
    input  logic                          Reset_In,
    input  logic [NUM_REQ-1:0]            Req_Valid_In,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data_In,
    output logic [NUM_REQ-1:0]            Req_Ready_Out,
    output logic                          Serial_Data_Out,
    output logic                          Frame_Active_Out,
    output logic [$clog2(NUM_REQ)-1:0]    Grant_Id_Out,
    output logic                          Done_Out
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IW-1:0] PTR_LAST = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [IW-1:0]          grant_q, grant_d;
    logic                   done_q, done_d;

    logic [DATA_WIDTH-1:0]  req_word [NUM_REQ];
    logic                   win_found;
    logic [IW-1:0]          win_id;
    logic [IW:0]            cand;
    logic                   accept;

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign req_word[g] = Req_Data_In[g*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Rotating priority search starting at the pointer. The candidate carries
    // one extra bit so pointer+i never overflows before the modulo fold.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_REQ)) begin
                cand = cand - (IW+1)'(NUM_REQ);
            end
            if (!win_found && Req_Valid_In[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[IW-1:0];
            end
        end
    end

    assign accept = (state_q == ST_IDLE) && win_found;

    // Ready is gated by the reset input so nothing is offered while the
    // block is held in reset, even though the state already reads idle.
    always_comb begin
        Req_Ready_Out = '0;
        if (accept && Reset_In) begin
            Req_Ready_Out[win_id] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shreg_d = req_word[win_id];
                    grant_d = win_id;
                    ptr_d   = (win_id == PTR_LAST) ? '0 : win_id + 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                if (cnt_q == CNT_LAST) begin
                    done_d  = 1'b1;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
        end
    end

    // Serial output is qualified by the frame strobe so it reads 0 outside a
    // frame, including immediately when reset aborts a frame.
    assign Frame_Active_Out = (state_q == ST_SHIFT);
    assign Serial_Data_Out  = Frame_Active_Out & shreg_q[DATA_WIDTH-1];
    assign Grant_Id_Out     = grant_q;
    assign Done_Out         = done_q;

endmodule

// File: tb/tb_siso_shift_arbiter.sv
// tb/tb_siso_shift_arbiter.sv - directed self-checking bench for siso_shift_arbiter
module tb_siso_shift_arbiter;

    logic        clk;
    logic        rst_n;

    logic [3:0]  v1;
    logic [31:0] d1;
    logic [3:0]  rdy1;
    logic        ser1, fa1, done1;
    logic [1:0]  gid1;

    logic [3:0]  v2;
    logic [31:0] d2;
    logic [3:0]  rdy2;
    logic        ser2, fa2, done2;
    logic [1:0]  gid2;

    int n_checks;
    int n_fail;

    siso_shift_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .GAP_CYCLES(1)) u_dut (
        .Clk_In           (clk),
        .Reset_In         (rst_n),
        .Req_Valid_In     (v1),
        .Req_Data_In      (d1),
        .Req_Ready_Out    (rdy1),
        .Serial_Data_Out  (ser1),
        .Frame_Active_Out (fa1),
        .Grant_Id_Out     (gid1),
        .Done_Out         (done1)
    );

    siso_shift_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .GAP_CYCLES(0)) u_dut_nogap (
        .Clk_In           (clk),
        .Reset_In         (rst_n),
        .Req_Valid_In     (v2),
        .Req_Data_In      (d2),
        .Req_Ready_Out    (rdy2),
        .Serial_Data_Out  (ser2),
        .Frame_Active_Out (fa2),
        .Grant_Id_Out     (gid2),
        .Done_Out         (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        rst_n = 1'b0;
        v1 = 4'hF; d1 = 32'h0;
        v2 = 4'hF; d2 = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (rdy1 !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", rdy1); end
        n_checks++; if (rdy2 !== 4'b0000) begin n_fail++; $display("FAIL reset_ready_nogap: got %b want 0000", rdy2); end
        n_checks++; if ({ser1, fa1, done1} !== 3'b000) begin n_fail++; $display("FAIL reset_outs: got ser/fa/done=%b want 000", {ser1, fa1, done1}); end
        n_checks++; if (gid1 !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d want 0", gid1); end
        @(negedge clk);
        rst_n = 1'b1;
        v1 = 4'b0001;
        v2 = 4'b0000;
        #1;
        n_checks++; if (rdy1 !== 4'b0001) begin n_fail++; $display("FAIL release_ready: got %b want 0001", rdy1); end
        v1 = 4'b0000;
    endtask

    task automatic test_single_frame();
        logic [7:0] b;
        b = 8'hA5;
        @(negedge clk);
        v1 = 4'b0001;
        d1 = {24'h0, b};
        #1;
        n_checks++; if (rdy1 !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", rdy1); end
        @(negedge clk);
        v1 = 4'b0010;
        d1 = 32'h0;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if ({fa1, ser1} !== {1'b1, b[7-i]}) begin n_fail++; $display("FAIL single_bit%0d: got fa/ser=%b want %b", i, {fa1, ser1}, {1'b1, b[7-i]}); end
            n_checks++; if (rdy1 !== 4'b0000) begin n_fail++; $display("FAIL single_ready_busy%0d: got %b want 0000", i, rdy1); end
            @(negedge clk);
        end
        n_checks++; if ({done1, fa1, ser1} !== 3'b100) begin n_fail++; $display("FAIL single_done: got done/fa/ser=%b want 100", {done1, fa1, ser1}); end
        n_checks++; if (gid1 !== 2'd0) begin n_fail++; $display("FAIL single_grant: got %0d want 0", gid1); end
        n_checks++; if (rdy1 !== 4'b0000) begin n_fail++; $display("FAIL single_gap_ready: got %b want 0000", rdy1); end
        @(negedge clk);
        n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %b want 0", done1); end
        n_checks++; if (rdy1 !== 4'b0010) begin n_fail++; $display("FAIL single_next_ready: got %b want 0010", rdy1); end
        v1 = 4'b0000;
    endtask

    task automatic test_fairness();
        logic [7:0] w;
        logic [1:0] g;
        logic [3:0] oh;
        int t;
        @(negedge clk);
        rst_n = 1'b0;
        v1 = 4'b0011;
        d1 = {16'h0, 8'h3C, 8'h5A};
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int f = 0; f < 4; f++) begin
            g  = (f % 2 == 0) ? 2'd0 : 2'd1;
            oh = 4'b0001 << g;
            case (f)
                0: w = 8'h5A;
                1: w = 8'h3C;
                2: w = 8'h96;
                default: w = 8'hC3;
            endcase
            d1[7:0]  = (f == 2) ? 8'h96 : 8'h5A;
            d1[15:8] = (f == 3) ? 8'hC3 : 8'h3C;
            t = 0;
            while (rdy1 == 4'b0000 && t < 30) begin
                @(negedge clk);
                #1;
                t++;
            end
            n_checks++; if (rdy1 !== oh) begin n_fail++; $display("FAIL fair_ready%0d: got %b want %b", f, rdy1, oh); end
            @(negedge clk);
            n_checks++; if (gid1 !== g) begin n_fail++; $display("FAIL fair_grant%0d: got %0d want %0d", f, gid1, g); end
            for (int i = 0; i < 8; i++) begin
                n_checks++; if ({fa1, ser1} !== {1'b1, w[7-i]}) begin n_fail++; $display("FAIL fair%0d_bit%0d: got fa/ser=%b want %b", f, i, {fa1, ser1}, {1'b1, w[7-i]}); end
                @(negedge clk);
            end
            n_checks++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL fair_done%0d: got %b want 1", f, done1); end
        end
        v1 = 4'b0000;
    endtask

    task automatic test_wrap();
        logic [3:0] vs [3];
        logic [1:0] gs [3];
        logic [3:0] oh;
        int t;
        vs[0] = 4'b0100; gs[0] = 2'd2;
        vs[1] = 4'b1000; gs[1] = 2'd3;
        vs[2] = 4'b1010; gs[2] = 2'd1;
        for (int s = 0; s < 3; s++) begin
            v1 = vs[s];
            oh = 4'b0001 << gs[s];
            #1;
            t = 0;
            while (rdy1 == 4'b0000 && t < 30) begin
                @(negedge clk);
                #1;
                t++;
            end
            n_checks++; if (rdy1 !== oh) begin n_fail++; $display("FAIL wrap_ready%0d: got %b want %b", s, rdy1, oh); end
            @(negedge clk);
            v1 = 4'b0000;
            n_checks++; if (gid1 !== gs[s]) begin n_fail++; $display("FAIL wrap_grant%0d: got %0d want %0d", s, gid1, gs[s]); end
            t = 0;
            while (done1 !== 1'b1 && t < 30) begin
                @(negedge clk);
                t++;
            end
            n_checks++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL wrap_done%0d: got %b want 1 (timeout)", s, done1); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int t;
        v1 = 4'b0001;
        d1 = {24'h0, 8'hFF};
        #1;
        t = 0;
        while (rdy1 == 4'b0000 && t < 30) begin
            @(negedge clk);
            #1;
            t++;
        end
        n_checks++; if (rdy1 !== 4'b0001) begin n_fail++; $display("FAIL mid_ready: got %b want 0001", rdy1); end
        @(negedge clk);
        v1 = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if ({fa1, ser1} !== 2'b11) begin n_fail++; $display("FAIL mid_bit%0d: got fa/ser=%b want 11", i, {fa1, ser1}); end
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        v1 = 4'hF;
        #1;
        n_checks++; if ({fa1, ser1} !== 2'b00) begin n_fail++; $display("FAIL mid_abort: got fa/ser=%b want 00", {fa1, ser1}); end
        n_checks++; if (rdy1 !== 4'b0000) begin n_fail++; $display("FAIL mid_ready_in_reset: got %b want 0000", rdy1); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL mid_no_done%0d: got %b want 0", i, done1); end
        end
        rst_n = 1'b1;
        #1;
        n_checks++; if (rdy1 !== 4'b0001) begin n_fail++; $display("FAIL mid_release_ready: got %b want 0001", rdy1); end
        v1 = 4'b0000;
        @(negedge clk);
        n_checks++; if ({done1, fa1} !== 2'b00) begin n_fail++; $display("FAIL mid_idle_after: got done/fa=%b want 00", {done1, fa1}); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] exp;
        a = 8'h81;
        b = 8'h7E;
        @(negedge clk);
        v2 = 4'b0100;
        d2 = {8'h0, a, 16'h0};
        #1;
        n_checks++; if (rdy2 !== 4'b0100) begin n_fail++; $display("FAIL b2b_ready: got %b want 0100", rdy2); end
        @(negedge clk);
        d2[23:16] = b;
        for (int c = 1; c <= 17; c++) begin
            if (c <= 8)       exp = {1'b1, a[8-c]};
            else if (c == 9)  exp = 2'b00;
            else              exp = {1'b1, b[17-c]};
            n_checks++; if ({fa2, ser2} !== exp) begin n_fail++; $display("FAIL b2b_cycle%0d: got fa/ser=%b want %b", c, {fa2, ser2}, exp); end
            if (c == 9) begin
                n_checks++; if ({done2, rdy2} !== 5'b10100) begin n_fail++; $display("FAIL b2b_overlap: got done/ready=%b want 10100", {done2, rdy2}); end
            end
            if (c == 10) v2 = 4'b0000;
            @(negedge clk);
        end
        n_checks++; if ({done2, fa2, ser2} !== 3'b100) begin n_fail++; $display("FAIL b2b_done2: got done/fa/ser=%b want 100", {done2, fa2, ser2}); end
        n_checks++; if (gid2 !== 2'd2) begin n_fail++; $display("FAIL b2b_grant: got %0d want 2", gid2); end
        @(negedge clk);
        n_checks++; if ({done2, fa2, rdy2} !== 6'b000000) begin n_fail++; $display("FAIL b2b_idle: got done/fa/ready=%b want 000000", {done2, fa2, rdy2}); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        v1 = '0; d1 = '0; v2 = '0; d2 = '0;
        test_reset();
        test_single_frame();
        test_fairness();
        test_wrap();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
